// File: rtl/axis_pe_source_pkg.sv
// Shared FSM encoding and parameter defaults for the AXIS PE source block.
package axis_pe_source_pkg;

  localparam int DEF_DATA_W     = 128;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_TIMEOUT    = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/axis_pe_src_fifo.sv
// Synchronous request FIFO; pushes while full and pops while empty are dropped.
module axis_pe_src_fifo
  import axis_pe_source_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W + 1,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axis_pe_source.sv
// Queues host requests, sends each as one AXIS beat to a PE and returns the
// PE response (or a timeout) as a one-cycle strobe; one transaction at a time.
module axis_pe_source
  import axis_pe_source_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_dest,
  output logic              req_ready,
  output logic              m_tvalid,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tdest,
  input  logic              m_tready,
  input  logic              s_tvalid,
  input  logic [DATA_W-1:0] s_tdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [DATA_W:0]  fifo_dout;

  assign req_ready = !fifo_full;
  assign fifo_pop  = !fifo_empty && (state == IDLE || state == RESP);
  assign busy      = (state != IDLE) || !fifo_empty;

  axis_pe_src_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_valid),
    .push_data ({req_dest, req_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A response arriving on the final timeout cycle still wins over the timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= '0;
      m_tvalid    <= 1'b0;
      m_tdata     <= '0;
      m_tdest     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            state               <= SEND;
            m_tvalid            <= 1'b1;
            {m_tdest, m_tdata}  <= fifo_dout;
          end
        end
        SEND: begin
          if (m_tready) begin
            state    <= WAIT;
            m_tvalid <= 1'b0;
            timer    <= '0;
          end
        end
        WAIT: begin
          if (s_tvalid) begin
            state       <= RESP;
            rsp_valid   <= 1'b1;
            rsp_data    <= s_tdata;
            rsp_timeout <= 1'b0;
          end else if (timer == CNT_W'(TIMEOUT)) begin
            state       <= RESP;
            rsp_valid   <= 1'b1;
            rsp_data    <= '0;
            rsp_timeout <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          if (fifo_pop) begin
            state              <= SEND;
            m_tvalid           <= 1'b1;
            {m_tdest, m_tdata} <= fifo_dout;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pe_source.sv
// Directed bench for axis_pe_source with a cycle-timeline reference model.
module tb_axis_pe_source;

  localparam int DATA_W     = 128;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 31;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic [DATA_W-1:0] req_data = '0;
  logic              req_dest = 1'b0;
  logic              req_ready;
  logic              m_tvalid;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tdest;
  logic              m_tready = 1'b0;
  logic              s_tvalid = 1'b0;
  logic [DATA_W-1:0] s_tdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_timeout;
  logic              busy;

  int checks = 0;
  int fails  = 0;

  axis_pe_source #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_dest    (req_dest),
    .req_ready   (req_ready),
    .m_tvalid    (m_tvalid),
    .m_tdata     (m_tdata),
    .m_tdest     (m_tdest),
    .m_tready    (m_tready),
    .s_tvalid    (s_tvalid),
    .s_tdata     (s_tdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Reference model: pending queue plus absolute edge numbers of launch,
  // handshake and response; outputs follow from those timestamps.
  logic [DATA_W:0] mq[$];
  logic [DATA_W:0] cur;
  bit              have;
  int              hs_at;
  int              rsp_at;
  int              cyc;
  logic [DATA_W-1:0] e_rsp_data;
  logic              e_rsp_to;

  always @(posedge clk or negedge reset) begin : model
    bit accept;
    int pre;
    if (!reset) begin
      mq.delete();
      cur        = '0;
      have       = 0;
      hs_at      = -1;
      rsp_at     = -100;
      cyc        = 0;
      e_rsp_data = '0;
      e_rsp_to   = 1'b0;
    end else begin
      cyc++;
      pre    = mq.size();
      accept = req_valid && (pre < FIFO_DEPTH);
      if (have && hs_at >= 0 && (s_tvalid || (cyc - hs_at == TIMEOUT + 1))) begin
        rsp_at     = cyc;
        have       = 0;
        hs_at      = -1;
        e_rsp_to   = !s_tvalid;
        e_rsp_data = s_tvalid ? s_tdata : '0;
      end else if (have && hs_at < 0 && m_tready) begin
        hs_at = cyc;
      end else if (!have && cyc > rsp_at && pre > 0) begin
        cur  = mq.pop_front();
        have = 1;
      end
      if (accept) mq.push_back({req_dest, req_data});
    end
  end

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("mdl_m_tvalid", m_tvalid, have && hs_at < 0);
    checkOutput("mdl_m_tdata", m_tdata, cur[DATA_W-1:0]);
    checkOutput("mdl_m_tdest", m_tdest, cur[DATA_W]);
    checkOutput("mdl_rsp_valid", rsp_valid, rsp_at == cyc);
    checkOutput("mdl_rsp_data", rsp_data, e_rsp_data);
    checkOutput("mdl_rsp_timeout", rsp_timeout, e_rsp_to);
    checkOutput("mdl_req_ready", req_ready, mq.size() < FIFO_DEPTH);
    checkOutput("mdl_busy", busy, have || (rsp_at == cyc) || (mq.size() > 0));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic dest);
    req_valid = 1'b1;
    req_data  = data;
    req_dest  = dest;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic waitMvalid(input int budget, input string name);
    int k = 0;
    while (m_tvalid !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    checkOutput(name, m_tvalid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    #1 reset = 1'b0;
    #2;
    checkOutput("rst_m_tvalid", m_tvalid, 1'b0);
    checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_req_ready", req_ready, 1'b1);
    checkOutput("rst_m_tdata", m_tdata, '0);
    checkOutput("rst_rsp_data", rsp_data, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Single request, response 20 cycles after the handshake.
    m_tready = 1'b1;
    applyStimulus(128'h1234, 1'b1);
    checkOutput("lat_edge1_m_tvalid", m_tvalid, 1'b0);
    tick();
    checkOutput("lat_edge2_m_tvalid", m_tvalid, 1'b1);
    checkOutput("lat_m_tdata", m_tdata, 128'h1234);
    checkOutput("lat_m_tdest", m_tdest, 1'b1);
    tick();
    checkOutput("hs_m_tvalid_low", m_tvalid, 1'b0);
    repeat (19) tick();
    checkOutput("rsp1_not_early", rsp_valid, 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 128'hABCD;
    tick();
    s_tvalid = 1'b0;
    checkOutput("rsp1_valid", rsp_valid, 1'b1);
    checkOutput("rsp1_data", rsp_data, 128'hABCD);
    checkOutput("rsp1_timeout", rsp_timeout, 1'b0);
    tick();
    checkOutput("rsp1_one_cycle", rsp_valid, 1'b0);
    checkOutput("rsp1_idle_busy", busy, 1'b0);

    // Backpressure for 5 cycles, then no PE response at all.
    m_tready = 1'b0;
    applyStimulus(128'h55, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_m_tvalid_%0d", i), m_tvalid, 1'b1);
      checkOutput($sformatf("bp_m_tdata_%0d", i), m_tdata, 128'h55);
      tick();
    end
    checkOutput("bp_m_tvalid_6th", m_tvalid, 1'b1);
    m_tready = 1'b1;
    tick();
    checkOutput("bp_hs_done", m_tvalid, 1'b0);
    k = 0;
    while (rsp_valid !== 1'b1 && k < 60) begin
      tick();
      k++;
    end
    checkOutput("to_latency", k, TIMEOUT + 1);
    checkOutput("to_flag", rsp_timeout, 1'b1);
    checkOutput("to_data", rsp_data, '0);
    tick();

    // Stray PE response while idle is ignored.
    s_tvalid = 1'b1;
    s_tdata  = 128'hBAD;
    tick();
    s_tvalid = 1'b0;
    checkOutput("stray_rsp_valid", rsp_valid, 1'b0);
    checkOutput("stray_rsp_data", rsp_data, '0);

    // Fill the FIFO while the FSM waits on a PE response.
    applyStimulus(128'hA0, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("fill_ready_%0d", i), req_ready, (i < 4));
      req_valid = 1'b1;
      req_data  = 128'hB0 + DATA_W'(i);
      req_dest  = i[0];
      tick();
    end
    req_valid = 1'b0;
    checkOutput("fill_full", req_ready, 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 128'hA5A5;
    tick();
    s_tvalid = 1'b0;
    checkOutput("fillA_rsp", rsp_data, 128'hA5A5);
    for (int j = 0; j < 4; j++) begin
      waitMvalid(10, $sformatf("b2b_m_tvalid_%0d", j));
      checkOutput($sformatf("b2b_m_tdata_%0d", j), m_tdata, 128'hB0 + DATA_W'(j));
      checkOutput($sformatf("b2b_m_tdest_%0d", j), m_tdest, j[0]);
      tick();
      repeat (2) tick();
      s_tvalid = 1'b1;
      s_tdata  = 128'hC0 + DATA_W'(j);
      tick();
      s_tvalid = 1'b0;
      checkOutput($sformatf("b2b_rsp_valid_%0d", j), rsp_valid, 1'b1);
      checkOutput($sformatf("b2b_rsp_data_%0d", j), rsp_data, 128'hC0 + DATA_W'(j));
    end
    repeat (3) tick();
    checkOutput("b2b_drained_busy", busy, 1'b0);
    checkOutput("b2b_fifth_dropped", m_tvalid, 1'b0);

    // Reset during WAIT with a second request queued.
    applyStimulus(128'h77, 1'b1);
    tick();
    tick();
    applyStimulus(128'h88, 1'b0);
    repeat (2) tick();
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_ready", req_ready, 1'b1);
    checkOutput("midrst_m_tvalid", m_tvalid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
    s_tvalid = 1'b1;
    s_tdata  = 128'hFEED;
    tick();
    s_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("postrst_rsp_valid_%0d", i), rsp_valid, 1'b0);
      checkOutput($sformatf("postrst_busy_%0d", i), busy, 1'b0);
      tick();
    end

    // PE response on the very cycle the timeout would fire.
    applyStimulus(128'h99, 1'b0);
    tick();
    tick();
    repeat (TIMEOUT) tick();
    checkOutput("race_not_early", rsp_valid, 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 128'hDEAD;
    tick();
    s_tvalid = 1'b0;
    checkOutput("race_rsp_valid", rsp_valid, 1'b1);
    checkOutput("race_timeout", rsp_timeout, 1'b0);
    checkOutput("race_data", rsp_data, 128'hDEAD);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/axis_pe_source.md
AXIS_PE_SOURCE -- requirements
Module: axis_pe_source

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning beat data width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning request FIFO entries (power of two, 2 or more).
REQ-003 SHALL have parameter TIMEOUT, default 31, meaning maximum cycles to wait for a PE response.
REQ-004 SHALL have one clock and an asynchronous active-low reset, as listed below.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  1  host request strobe.
REQ-008 req_data  input  DATA_W  host payload.
REQ-009 req_dest  input  1  host tdest.
REQ-010 req_ready  output  1  high when the FIFO is not full.
REQ-011 m_tvalid  output  1  AXIS master valid towards the PE.
REQ-012 m_tdata  output  DATA_W  AXIS master data.
REQ-013 m_tdest  output  1  AXIS master tdest.
REQ-014 m_tready  input  1  PE tready.
REQ-015 s_tvalid  input  1  PE response valid (single-cycle pulse).
REQ-016 s_tdata  input  DATA_W  PE response data.
REQ-017 rsp_valid  output  1  one-cycle response strobe.
REQ-018 rsp_data  output  DATA_W  captured response.
REQ-019 rsp_timeout  output  1  qualifies rsp_valid; high means no PE response arrived.
REQ-020 busy  output  1  high when the FSM is not in IDLE or the FIFO is non-empty.

Function
REQ-021 A request SHALL be accepted on a cycle with req_valid and req_ready both high; requests presented while the FIFO is full SHALL be ignored.
REQ-022 FSM states: IDLE, SEND, WAIT, RESP.
- IDLE->SEND when the FIFO is non-empty; the head entry is popped into the output register on the same edge.
REQ-023 In SEND, m_tvalid SHALL be 1.
- m_tdata and m_tdest SHALL stay stable until m_tvalid and m_tready are both high (AXIS rule: tvalid never drops without a handshake).
REQ-024 SEND->WAIT on the handshake cycle; the timeout counter SHALL clear to 0 on that edge.
REQ-025 In WAIT, the counter SHALL increment by 1 each cycle.
- s_tvalid high: capture s_tdata, go to RESP with the timeout flag cleared.
- counter == TIMEOUT with no s_tvalid: go to RESP with the timeout flag set and rsp_data = 0.
REQ-026 If s_tvalid and counter == TIMEOUT occur in the same cycle, the response SHALL win and the timeout flag SHALL stay clear.
REQ-027 RESP SHALL assert rsp_valid for exactly one cycle, then go to IDLE.
- Back-to-back: if the FIFO is non-empty, RESP->SEND directly with the head popped.
REQ-028 At most one transaction SHALL be outstanding; m_tvalid SHALL be 0 in IDLE, WAIT and RESP.
REQ-029 s_tvalid outside WAIT SHALL be ignored, with no capture and no rsp_valid.
REQ-030 The counter width SHALL be clog2(TIMEOUT+1), and the counter SHALL never wrap.
REQ-031 FIFO occupancy width SHALL be clog2(FIFO_DEPTH)+1.
- Simultaneous push and pop at full or at empty SHALL keep the count consistent.
- Push while full SHALL be dropped; pop while empty SHALL never occur.
REQ-032 Request-to-m_tvalid latency SHALL be 2 cycles when idle and the FIFO is empty.

Reset
REQ-033 On reset low, the block SHALL immediately clear:
- FSM to IDLE;
- FIFO to empty;
- counter to 0;
- m_tvalid, rsp_valid, rsp_timeout and busy to 0;
- req_ready to 1;
- m_tdata and rsp_data to 0.
REQ-034 Reset mid-transaction SHALL abandon the transaction and emit no rsp_valid.
REQ-035 The block SHALL leave reset cleanly on the first rising clk edge after reset rises.

Structure
REQ-036 The shared package SHALL hold:
- the FSM state encoding (2-bit IDLE=0, SEND=1, WAIT=2, RESP=3);
- DATA_W, FIFO_DEPTH and TIMEOUT defaults.
REQ-037 The request FIFO SHALL be the sub-module axis_pe_src_fifo (width DATA_W+1, synchronous, same clk/reset).
- Exposes push, pop, full and empty.

Verification
REQ-038 Single request, data 0x1234 with m_tready=1, PE responds 20 cycles after the handshake with 0xABCD:
- required response: rsp_valid for one cycle with rsp_data=0xABCD and rsp_timeout=0.
REQ-039 Hold m_tready=0 for 5 cycles:
- required response: m_tvalid held high with m_tdata unchanged; the handshake occurs on the 6th cycle.
REQ-040 No s_tvalid after the handshake:
- required response: rsp_valid with rsp_timeout=1 exactly TIMEOUT+1 cycles after the handshake (32 cycles at default).
REQ-041 Push 5 back-to-back requests with the FSM stalled in WAIT:
- required response: 4 accepted and the 5th dropped (req_ready=0); then 4 ordered transactions, each with its own rsp_valid.
REQ-042 Assert reset low during WAIT, then inject s_tvalid after release:
- required response: no rsp_valid, busy=0, FIFO empty.
REQ-043 s_tvalid coincident with counter == TIMEOUT:
- required response: rsp_timeout=0 and rsp_data captured.
